// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling.
//
// Parameters
//   CLK_FREQ_HZ : clk frequency in Hz
//   BAUD_RATE   : serial bit rate in bit/s (CLK_FREQ_HZ/BAUD_RATE must be >= 4)
// Ports
//   clk         : rising-edge clock
//   reset       : synchronous reset, active low
//   i_rx        : asynchronous serial line, idle high
//   o_data      : last correctly received byte
//   o_valid     : one-cycle pulse, o_data newly updated
//   o_frame_err : one-cycle pulse, stop bit sampled low
//   o_busy      : high while a frame (or a break) is in progress
module uart_rx #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state, nxt;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            bit_done, half_done;
  logic            valid_set, ferr_set, data_smp;

  assign bit_done  = (cnt == BIT_LAST);
  assign half_done = (cnt == HALF_LAST);

  // Two-flop synchronizer; resets to the idle (mark) level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (!rx_s) nxt = START;
      // Re-check at mid start bit: a line already back high was a glitch.
      START:     if (half_done) nxt = rx_s ? IDLE : DATA;
      DATA:      if (bit_done && bit_idx == 3'd7) nxt = STOP;
      STOP:      if (bit_done) nxt = rx_s ? IDLE : WAIT_IDLE;
      // Break / bad stop: wait for mark before hunting for a new start bit.
      WAIT_IDLE: if (rx_s) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    o_busy    = (state != IDLE);
    data_smp  = (state == DATA) && bit_done;
    valid_set = (state == STOP) && bit_done &&  rx_s;
    ferr_set  = (state == STOP) && bit_done && !rx_s;
  end

  // Datapath: bit-period counter, bit index, holding register, outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= valid_set;
      o_frame_err <= ferr_set;
      if (valid_set) o_data <= shreg;
      if (data_smp) begin
        shreg[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;  // wraps to 0 after bit 7
      end
      unique case (state)
        START:   cnt <= half_done ? '0 : cnt + 1'b1;
        DATA,
        STOP:    cnt <= bit_done  ? '0 : cnt + 1'b1;
        default: begin
          cnt     <= '0;
          bit_idx <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
  localparam int CLK_FREQ_HZ = 1600;
  localparam int BAUD_RATE   = 100;
  localparam int CPB         = CLK_FREQ_HZ / BAUD_RATE;
  // Line edge to pulse: 2 sync flops + 1 detect edge, then half a bit to
  // the start-bit centre and 9 whole bits to the stop-bit centre.
  localparam int PULSE_LAT   = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_busy;

  uart_rx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .reset(reset), .i_rx(i_rx),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_data = 8'h00;
  logic       prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one 8N1 frame starting now; the expected pulse is queued first.
  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input int hold_low);
    exp_t e;
    e.ferr    = bad_stop;
    e.data    = b;
    e.exp_cyc = cyc + PULSE_LAT;
    sb.push_back(e);
    i_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) tick();
    end
    i_rx = !bad_stop;
    repeat (CPB) tick();
    if (bad_stop) repeat (hold_low) tick();
  endtask

  // Monitor: pops the scoreboard on every pulse and tracks o_data.
  always @(negedge clk) begin
    check("valid_ferr_overlap", o_valid & o_frame_err, 1'b0);
    if (o_valid || o_frame_err) begin
      if (sb.size() == 0) begin
        check("pulse_with_empty_queue", {o_valid, o_frame_err}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_is_ferr", o_frame_err, mon_e.ferr);
        check("pulse_cycle", cyc, mon_e.exp_cyc);
        if (!mon_e.ferr) begin
          exp_data = mon_e.data;
          check("busy_falls_with_valid", {prev_busy, o_busy}, 2'b10);
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
      check("pulse_missing", {o_valid, o_frame_err}, sb[0].ferr ? 2'b01 : 2'b10);
      void'(sb.pop_front());
    end
    check("o_data", o_data, exp_data);
    prev_busy = o_busy;
  end

  initial begin
    int guard;
    logic [7:0] b;
    bit bad;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    check("rst_o_data", o_data, 8'h00);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_frame_err", o_frame_err, 1'b0);
    check("rst_o_busy", o_busy, 1'b0);
    reset = 1'b1;
    repeat (3) tick();
    check("busy_after_release", o_busy, 1'b0);
    idle(5);

    // Clean frame
    send_frame(8'hA5, 1'b0, 0);
    idle(10);
    check("busy_idle_after_a5", o_busy, 1'b0);

    // Back-to-back, no gap
    send_frame(8'h48, 1'b0, 0);
    send_frame(8'h69, 1'b0, 0);
    idle(10);

    // Start-bit glitch
    i_rx = 1'b0;
    repeat (4) tick();
    check("glitch_busy_set", o_busy, 1'b1);
    i_rx = 1'b1;
    repeat (10) tick();
    check("glitch_busy_clear", o_busy, 1'b0);
    idle(10);

    // Bad stop bit followed by a held break, then recovery
    send_frame(8'h3C, 1'b1, 40);
    check("break_busy", o_busy, 1'b1);
    idle(5);
    check("break_released_busy", o_busy, 1'b0);
    send_frame(8'h5A, 1'b0, 0);
    idle(10);

    // Reset in the middle of data bit 4: frame abandoned, no pulse
    i_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      i_rx = (i % 2 == 0);
      repeat (CPB) tick();
    end
    i_rx = 1'b0;
    repeat (CPB / 2) tick();
    reset = 1'b0;
    i_rx  = 1'b1;
    tick();
    exp_data = 8'h00;
    check("abort_o_data", o_data, 8'h00);
    check("abort_o_valid", o_valid, 1'b0);
    check("abort_o_frame_err", o_frame_err, 1'b0);
    check("abort_o_busy", o_busy, 1'b0);
    reset = 1'b1;
    idle(20);
    send_frame(8'hFF, 1'b0, 0);
    idle(10);

    // Randomized traffic, occasional framing errors and back-to-back frames
    for (int n = 0; n < 24; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, bad, int'($urandom_range(0, 40)));
      if (bad) idle(int'($urandom_range(2, 6)));
      else     idle(int'($urandom_range(0, 3)));
    end

    guard = 0;
    while (sb.size() > 0 && guard < 400) begin
      tick();
      guard++;
    end
    check("scoreboard_drained", sb.size(), 0);
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ_HZ, default 12000000, giving the clk frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600, giving the serial bit rate in bit/s.
REQ-003 The module SHALL derive a local constant CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, using integer division.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-006 The module SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The module SHALL have port o_data, output, 8 bits: last correctly received byte.
REQ-008 The module SHALL have port o_valid, output, 1 bit: one-cycle pulse, o_data newly updated.
REQ-009 The module SHALL have port o_frame_err, output, 1 bit: one-cycle pulse, stop bit sampled low.
REQ-010 The module SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer, reset to 1; all decisions use the synchronized value rx_s.
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, no parity, one stop bit 1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, and WAIT_IDLE.
REQ-014 In IDLE with rx_s == 0, the FSM SHALL go to START and clear the bit-period counter.
REQ-015 In START, at counter == CLKS_PER_BIT/2 - 1, the FSM SHALL resample rx_s: 0 goes to DATA with the counter cleared; 1 is a glitch and returns to IDLE with no output pulse.
REQ-016 In DATA, each bit SHALL be sampled at counter == CLKS_PER_BIT - 1 (mid-bit), the counter then clearing.
REQ-017 Sampled data bits SHALL shift into a holding register at index 0..7, and a 3-bit index SHALL count the bits.
REQ-018 After bit index 7, the FSM SHALL go to STOP.
REQ-019 In STOP, at counter == CLKS_PER_BIT - 1, the FSM SHALL act on the stop sample.
  - Stop sample 1: load o_data from the holding register, pulse o_valid high for exactly one cycle, go to IDLE.
  - Stop sample 0: leave o_data unchanged, pulse o_frame_err high for exactly one cycle, go to WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL remain until rx_s == 1, then go to IDLE; a held-low line (break) SHALL NOT produce further frames.
REQ-021 o_valid and o_frame_err SHALL never be high in the same cycle, and each SHALL be low in every cycle other than its pulse.
REQ-022 The counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never exceed CLKS_PER_BIT - 1.
REQ-023 Latency: the o_valid pulse SHALL occur in the cycle after the stop-bit mid-point sample edge, and o_data SHALL hold stable until the next o_valid.
REQ-024 A new start bit that follows a valid stop bit SHALL be accepted from IDLE with no dead cycles beyond the IDLE transition.
REQ-025 The block SHALL not be reconfigurable at runtime; CLKS_PER_BIT >= 4 is required, and smaller values are unsupported.

Reset
REQ-026 While reset == 0 at a clk edge, the following SHALL take effect on that edge regardless of state, including mid-frame:
  - state goes to IDLE; counter, bit index and holding register go to 0;
  - o_data = 8'h00, o_valid = 0, o_frame_err = 0, o_busy = 0;
  - both synchronizer flops go to 1.
REQ-027 A frame interrupted by reset SHALL be discarded with no pulse on o_valid or o_frame_err after reset releases.

Verification (CLK_FREQ_HZ=1600, BAUD_RATE=100, so CLKS_PER_BIT=16)
REQ-028 Send byte 8'hA5 as a clean 8N1 frame -> exactly one o_valid pulse, o_data == 8'hA5, o_frame_err stays 0, o_busy falls with the pulse.
REQ-029 Send back-to-back 8'h48 then 8'h69 with no idle gap -> two o_valid pulses, in that order, 160 clks apart, with the matching data.
REQ-030 Pull i_rx low for 4 clks, then high -> no pulses, o_busy returns to 0 within 10 clks, o_data unchanged.
REQ-031 Send 8'h3C with the stop bit driven 0, holding 0 for 40 more clks -> one o_frame_err pulse, o_data keeps its prior value, no frame decoded until i_rx returns high and a new start bit arrives.
REQ-032 Assert reset low for 1 clk during data bit 4 of a frame -> all outputs at reset values on the next cycle, no pulse for the aborted frame, and the next clean 8'hFF frame is received correctly.
